// File: rtl/mult_div_unit.sv
// Iterative 33-cycle MULT/MULTU/DIV/DIVU unit with MTHI/MTLO writes for the MIPS execute stage.
// Define MULTDIV_DIV_EN to compile in the restoring divider; otherwise divide commands are ignored.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] opA,
  input  logic [WIDTH-1:0] opB,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FINISH} state_e;

  state_e             state_q;
  logic [CW-1:0]      count_q;
  logic               busy_q, done_q, neg_q;
  logic [WIDTH-1:0]   hi_q, lo_q, opnd_q;
  logic [2*WIDTH-1:0] acc_q;

  logic               signed_op, a_neg, b_neg, accept;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] prod;

  // Operands are reduced to magnitudes on entry; 0x80000000 maps to 2^31 unsigned.
  assign signed_op = ~op[0];
  assign a_neg     = signed_op & opA[WIDTH-1];
  assign b_neg     = signed_op & opB[WIDTH-1];
  assign mag_a     = a_neg ? -opA : opA;
  assign mag_b     = b_neg ? -opB : opB;

  // Shift-add step: the multiplier occupies the low half of acc_q and is consumed LSB first.
  assign mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? opnd_q : '0)};
  assign prod    = neg_q ? -acc_q : acc_q;

`ifdef MULTDIV_DIV_EN
  logic             is_div_q, a_neg_q, b_zero_q;
  logic [WIDTH-1:0] raw_a_q, rem_q;
  logic [WIDTH:0]   div_shift;
  logic             div_ge;
  logic [WIDTH-1:0] div_rem, quot, rem_signed;

  // Restoring step: the partial remainder is WIDTH+1 bits wide only while shifted.
  assign div_shift  = {rem_q, acc_q[WIDTH-1]};
  assign div_ge     = div_shift >= {1'b0, opnd_q};
  assign div_rem    = div_ge ? (div_shift[WIDTH-1:0] - opnd_q) : div_shift[WIDTH-1:0];
  assign quot       = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
  assign rem_signed = a_neg_q ? -rem_q : rem_q;
  assign accept     = start;
`else
  assign accept     = start & ~op[1];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      count_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      neg_q    <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      opnd_q   <= '0;
      acc_q    <= '0;
`ifdef MULTDIV_DIV_EN
      is_div_q <= 1'b0;
      a_neg_q  <= 1'b0;
      b_zero_q <= 1'b0;
      raw_a_q  <= '0;
      rem_q    <= '0;
`endif
    end else begin
      // NOTE: non-blocking assignments keep every register update based on pre-edge values.
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (hi_we) hi_q <= wdata;
          if (lo_we) lo_q <= wdata;
          if (accept) begin
            state_q <= S_RUN;
            busy_q  <= 1'b1;
            count_q <= '0;
            neg_q   <= a_neg ^ b_neg;
`ifdef MULTDIV_DIV_EN
            is_div_q <= op[1];
            a_neg_q  <= a_neg;
            b_zero_q <= (opB == '0);
            raw_a_q  <= opA;
            rem_q    <= '0;
            opnd_q   <= op[1] ? mag_b : mag_a;
            acc_q    <= {{WIDTH{1'b0}}, (op[1] ? mag_a : mag_b)};
`else
            opnd_q   <= mag_a;
            acc_q    <= {{WIDTH{1'b0}}, mag_b};
`endif
          end
        end
        S_RUN: begin
`ifdef MULTDIV_DIV_EN
          if (is_div_q) begin
            acc_q <= {{WIDTH{1'b0}}, acc_q[WIDTH-2:0], div_ge};
            rem_q <= div_rem;
          end else begin
            acc_q <= {mul_sum, acc_q[WIDTH-1:1]};
          end
`else
          acc_q <= {mul_sum, acc_q[WIDTH-1:1]};
`endif
          count_q <= count_q + 1'b1;
          if (count_q == LAST_ITER) state_q <= S_FINISH;
        end
        S_FINISH: begin
`ifdef MULTDIV_DIV_EN
          if (is_div_q && b_zero_q) begin
            hi_q <= raw_a_q;
            lo_q <= '1;
          end else if (is_div_q) begin
            hi_q <= rem_signed;
            lo_q <= quot;
          end else begin
            hi_q <= prod[2*WIDTH-1:WIDTH];
            lo_q <= prod[WIDTH-1:0];
          end
`else
          hi_q <= prod[2*WIDTH-1:WIDTH];
          lo_q <= prod[WIDTH-1:0];
`endif
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: issued commands queue {HI,LO} from an arithmetic model,
// a monitor pops and compares on every done pulse.
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        rst_n, start, hi_we, lo_we, busy, done;
  logic [1:0]  op;
  logic [31:0] opA, opB, wdata, hi, lo;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] exp;
  } txn_t;

  txn_t sb[$];
  txn_t mon_t;
  int   checks = 0;
  int   errors = 0;
  int   done_seen = 0;

  always #5 clk = ~clk;

  mult_div_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .opA(opA), .opB(opB),
    .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic; / and % truncate toward zero, remainder follows dividend.
  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sbv, q, r;
    logic [63:0] ua, ub;
    sa  = longint'($signed(a));
    sbv = longint'($signed(b));
    ua  = {32'b0, a};
    ub  = {32'b0, b};
    if (o == 2'b00) return 64'(sa * sbv);
    if (o == 2'b01) return ua * ub;
    if (b == 32'b0) return {a, 32'hFFFF_FFFF};
    if (o == 2'b10) begin
      q = sa / sbv;
      r = sa % sbv;
    end else begin
      q = longint'(ua / ub);
      r = longint'(ua % ub);
    end
    return {r[31:0], q[31:0]};
  endfunction

  always @(negedge clk) begin
    if (rst_n && done) begin
      done_seen++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 with empty scoreboard, expected no pulse");
      end else begin
        mon_t = sb.pop_front();
        check($sformatf("result op=%0d a=%h b=%h", mon_t.op, mon_t.a, mon_t.b), {hi, lo}, mon_t.exp);
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic wait_idle();
    for (int i = 0; i < 100 && busy; i++) @(negedge clk);
    if (busy) check("idle_timeout", {63'b0, busy}, 64'd0);
  endtask

  task automatic push_exp(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    txn_t t;
    t.op = o; t.a = a; t.b = b; t.exp = model(o, a, b);
    sb.push_back(t);
  endtask

  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    wait_idle();
    op = o; opA = a; opB = b; start = 1'b1;
    push_exp(o, a, b);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic mt_write(input bit to_hi, input logic [31:0] v);
    hi_we = to_hi; lo_we = ~to_hi; wdata = v;
    @(negedge clk);
    hi_we = 1'b0; lo_we = 1'b0;
    check(to_hi ? "mthi" : "mtlo", to_hi ? {32'b0, hi} : {32'b0, lo}, {32'b0, v});
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'h1;
      default: return $urandom();
    endcase
  endfunction

  initial begin
    int n, k, saved;
    rst_n = 1'b1; start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    op = 2'b00; opA = '0; opB = '0; wdata = '0;
    #2 rst_n = 1'b0;
    #1;
    check("reset_hilo", {hi, lo}, 64'd0);
    check("reset_busy_done", {62'b0, busy, done}, 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // MULTU max x max with cycle-exact busy/done timing.
    issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check("busy_at_E0", {63'b0, busy}, 64'd1);
    n = 1;
    for (k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (!busy) break;
      n++;
    end
    check("busy_cycles", 64'(n), 64'd33);
    check("done_edge", 64'(k), 64'd33);
    check("done_at_E33", {63'b0, done}, 64'd1);
    @(negedge clk);
    check("done_low_E34", {63'b0, done}, 64'd0);

    issue(2'b00, 32'hFFFF_FFFD, 32'h0000_0007);
    issue(2'b00, 32'h8000_0000, 32'h8000_0000);
    wait_idle();
    @(negedge clk);

    mt_write(1'b1, 32'h1234_5678);
    mt_write(1'b0, 32'hCAFE_BABE);
    check("hi_held_after_mtlo", {32'b0, hi}, 64'h1234_5678);

`ifdef MULTDIV_DIV_EN
    issue(2'b10, 32'hFFFF_FFF9, 32'h0000_0002);
    issue(2'b11, 32'h0000_0064, 32'h0000_0000);
    issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
    issue(2'b10, 32'hFFFF_FFF9, 32'h0000_0000);
    wait_idle();
    @(negedge clk);
`else
    saved = done_seen;
    op = 2'b10; opA = 32'd100; opB = 32'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("div_ignored_busy", {63'b0, busy}, 64'd0);
      @(negedge clk);
    end
    check("div_ignored_hilo", {hi, lo}, 64'h1234_5678_CAFE_BABE);
    check("div_ignored_done", 64'(done_seen), 64'(saved));
`endif

    // Commands and MTHI arriving mid-operation must not disturb it.
    mt_write(1'b1, 32'h0BAD_F00D);
    issue(2'b01, 32'd5, 32'd6);
    repeat (9) @(negedge clk);
    op = 2'b11; opA = 32'd9; opB = 32'd3; start = 1'b1; hi_we = 1'b1; wdata = 32'h1234_5678;
    @(negedge clk);
    start = 1'b0; hi_we = 1'b0;
    check("busy_write_ignored", {32'b0, hi}, 64'h0BAD_F00D);
    wait_idle();
    @(negedge clk);
    check("no_extra_busy", {63'b0, busy}, 64'd0);

    // start together with MTHI in IDLE: write lands first, FINISH overwrites.
    op = 2'b01; opA = 32'd3; opB = 32'd4; start = 1'b1; hi_we = 1'b1; wdata = 32'hDEAD_0001;
    push_exp(2'b01, 32'd3, 32'd4);
    @(negedge clk);
    start = 1'b0; hi_we = 1'b0;
    check("start_with_mthi", {32'b0, hi}, 64'hDEAD_0001);
    wait_idle();
    @(negedge clk);

    // Asynchronous reset in the middle of a MULTU.
    issue(2'b01, 32'd7, 32'd9);
    repeat (14) @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("midreset_hilo", {hi, lo}, 64'd0);
    check("midreset_busy_done", {62'b0, busy, done}, 64'd0);
    sb.delete();
    saved = done_seen;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    check("midreset_no_done", 64'(done_seen), 64'(saved));
    issue(2'b01, 32'd2, 32'd3);

    // Random back-to-back traffic including the sign and zero corners.
    for (int i = 0; i < 40; i++) begin
`ifdef MULTDIV_DIV_EN
      issue(2'($urandom_range(0, 3)), pick(), pick());
`else
      issue(2'($urandom_range(0, 1)), pick(), pick());
`endif
    end
    wait_idle();
    repeat (2) @(negedge clk);
    check("scoreboard_drained", 64'(sb.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
